// File: rtl/data_types_pkg.sv
// rtl/data_types_pkg.sv - shared UART configuration, state encoding and sizing constants
package data_types_pkg;

    localparam int OVS_DEFAULT = 16;
    localparam int MAX_WORD    = 9;
    localparam int BR_DIV_W    = 16;

    // One config register drives both the transmitter and the receiver
    typedef struct packed {
        logic [BR_DIV_W-1:0] br_div;  // clk cycles per bit
        logic                word;    // 1 = 9 data bits, 0 = 8
        logic                stop;    // 1 = 2 stop bits, 0 = 1
    } config_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-word holding register handshake between receiver and consumer
interface uart_rx_if;
    import data_types_pkg::*;

    logic [MAX_WORD-1:0] data;
    logic                valid;
    logic                ack;
    logic                frame_err;
    logic                overrun;

    modport master (output data, valid, frame_err, overrun, input ack);
    modport slave  (input data, valid, frame_err, overrun, output ack);
endinterface

// File: rtl/baud_gen.sv
// rtl/baud_gen.sv - periodic single-cycle tick every div clocks, held cleared by clr
module baud_gen #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [W-1:0] div,
    output logic         tick
);
    localparam logic [W-1:0] ONE = 1;

    logic [W-1:0] cnt;

    // Count div clocks and emit a registered tick on wrap; clr restarts the phase
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == div - ONE) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + ONE;
            tick <= 1'b0;
        end
    end
endmodule

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rx_sync: multi-flop synchronizer for the async serial line, resets to idle-high
module rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    // Shift the raw line through STAGES flops; reset to 1 so no false start appears
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ff <= '1;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with single-entry valid/ack holding register
module uart_rx
    import data_types_pkg::*;
#(
    parameter int OVS         = OVS_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx_in,
    input  config_t   rx_cfg,
    input  logic      enable,
    output logic      idle,
    uart_rx_if.master bus
);
    localparam int                SC_W    = $clog2(OVS);
    localparam logic [SC_W-1:0]   SC_MID  = SC_W'(OVS / 2 - 1);
    localparam logic [SC_W-1:0]   SC_LAST = SC_W'(OVS - 1);

    state_t                 state;
    logic                   rx;
    logic                   tick;
    logic [SC_W-1:0]        sc;
    logic [3:0]             dc;
    logic [MAX_WORD-1:0]    sh;
    logic [BR_DIV_W-1:0]    div_sh;
    logic                   word_sh;
    logic                   stop_sh;
    logic                   stop2;   // first of two stop bits already sampled
    logic                   ferr;    // sticky: some stop sample was 0
    logic                   done;    // final stop sampled; complete next cycle

    rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_in),
        .q     (rx)
    );

    // Tick phase restarts at every frame because the generator is held while idle
    baud_gen #(.W(BR_DIV_W)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == IDLE),
        .div   (div_sh),
        .tick  (tick)
    );

    // Frame state machine, shift register, counters and holding register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            idle          <= 1'b1;
            sc            <= '0;
            dc            <= '0;
            sh            <= '0;
            div_sh        <= '0;
            word_sh       <= 1'b0;
            stop_sh       <= 1'b0;
            stop2         <= 1'b0;
            ferr          <= 1'b0;
            done          <= 1'b0;
            bus.data      <= '0;
            bus.valid     <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
            if (bus.ack) begin
                bus.valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx && enable) begin
                        // Shadow the config so mid-frame changes cannot corrupt this frame
                        div_sh  <= rx_cfg.br_div >> SC_W;
                        word_sh <= rx_cfg.word;
                        stop_sh <= rx_cfg.stop;
                        dc      <= rx_cfg.word ? 4'd8 : 4'd7;
                        sc      <= '0;
                        sh      <= '0;
                        ferr    <= 1'b0;
                        stop2   <= 1'b0;
                        done    <= 1'b0;
                        state   <= START;
                        idle    <= 1'b0;
                    end
                end

                START: begin
                    if (tick) begin
                        if (sc == SC_MID) begin
                            if (rx) begin
                                state <= IDLE;
                                idle  <= 1'b1;
                            end else begin
                                sc    <= '0;
                                state <= DATA;
                            end
                        end else begin
                            sc <= sc + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        sc <= sc + 1'b1;
                        if (sc == SC_LAST) begin
                            sh <= {sh[MAX_WORD-2:0], rx};
                            if (dc == 4'd0) begin
                                state <= STOP;
                            end else begin
                                dc <= dc - 1'b1;
                            end
                        end
                    end
                end

                STOP: begin
                    if (done) begin
                        bus.data      <= word_sh ? sh : {1'b0, sh[MAX_WORD-2:0]};
                        bus.valid     <= 1'b1;
                        bus.frame_err <= ferr;
                        bus.overrun   <= bus.valid && !bus.ack;
                        done          <= 1'b0;
                        state         <= IDLE;
                        idle          <= 1'b1;
                    end else if (tick) begin
                        sc <= sc + 1'b1;
                        if (sc == SC_LAST) begin
                            ferr <= ferr | ~rx;
                            if (stop_sh && !stop2) begin
                                stop2 <= 1'b1;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    idle  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard testbench for uart_rx
module tb_uart_rx;
    import data_types_pkg::*;

    localparam int BIT = 160;

    typedef struct packed {
        logic [8:0] data;
        logic       fe;
        logic       ov;
    } exp_t;

    logic    clk    = 1'b0;
    logic    rst_n  = 1'b0;
    logic    rx_in  = 1'b1;
    logic    enable = 1'b0;
    config_t cfg;
    logic    idle;

    uart_rx_if bus ();

    uart_rx #(.OVS(16), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_in  (rx_in),
        .rx_cfg (cfg),
        .enable (enable),
        .idle   (idle),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    exp_t e_mon;
    int   checks   = 0;
    int   failures = 0;
    int   events   = 0;
    int   ferr_len = 0;
    int   ferr_max = 0;
    int   ev_mark  = 0;
    logic valid_q  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic bit_out(input logic b);
        rx_in = b;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [8:0] v, input int nbits, input int nstop,
                        input logic stop_val, input logic drop_en);
        bit_out(1'b0);
        if (drop_en) enable = 1'b0;
        for (int i = nbits - 1; i >= 0; i--) bit_out(v[i]);
        for (int i = 0; i < nstop; i++) bit_out(stop_val);
        rx_in = 1'b1;
    endtask

    task automatic ack_pulse();
        bus.ack = 1'b1;
        @(posedge clk);
        #1;
        bus.ack = 1'b0;
        chk("valid_after_ack", bus.valid, 1'b0);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every completion (valid rise or overrun pulse) is matched against the queue
    always @(negedge clk) begin
        if (bus.frame_err) ferr_len++;
        else ferr_len = 0;
        if (ferr_len > ferr_max) ferr_max = ferr_len;
        if ((bus.valid && !valid_q) || bus.overrun) begin
            events++;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=%0h required=none", bus.data);
            end else begin
                e_mon = q.pop_front();
                chk("word_data", 32'(bus.data), 32'(e_mon.data));
                chk("word_frame_err", 32'(bus.frame_err), 32'(e_mon.fe));
                chk("word_overrun", 32'(bus.overrun), 32'(e_mon.ov));
            end
        end
        valid_q = bus.valid;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ack = 1'b0;
        cfg = '{br_div: 16'd160, word: 1'b0, stop: 1'b0};
        settle(5);
        chk("reset_idle", idle, 1'b1);
        chk("reset_valid", bus.valid, 1'b0);
        chk("reset_data", 32'(bus.data), 32'h0);
        chk("reset_frame_err", bus.frame_err, 1'b0);
        chk("reset_overrun", bus.overrun, 1'b0);
        rst_n  = 1'b1;
        enable = 1'b1;
        settle(20);

        // 8 bits, 1 stop
        q.push_back('{9'h0A5, 1'b0, 1'b0});
        send(9'h0A5, 8, 1, 1'b1, 1'b0);
        settle(5);
        chk("a5_idle", idle, 1'b1);
        chk("a5_valid", bus.valid, 1'b1);
        chk("a5_data", 32'(bus.data), 32'h0A5);
        ack_pulse();

        // 9 bits, 2 stops
        cfg = '{br_div: 16'd160, word: 1'b1, stop: 1'b1};
        q.push_back('{9'h1C3, 1'b0, 1'b0});
        send(9'h1C3, 9, 2, 1'b1, 1'b0);
        settle(5);
        chk("1c3_valid", bus.valid, 1'b1);
        chk("1c3_data", 32'(bus.data), 32'h1C3);
        ack_pulse();

        // False start: 4 ticks low
        cfg = '{br_div: 16'd160, word: 1'b0, stop: 1'b0};
        ev_mark = events;
        rx_in = 1'b0;
        settle(40);
        rx_in = 1'b1;
        settle(400);
        chk("false_start_idle", idle, 1'b1);
        chk("false_start_valid", bus.valid, 1'b0);
        chk("false_start_events", events, ev_mark);

        // Stop bit forced low; enable dropped mid-frame
        ferr_max = 0;
        q.push_back('{9'h055, 1'b1, 1'b0});
        send(9'h055, 8, 1, 1'b0, 1'b1);
        settle(400);
        enable = 1'b1;
        chk("ferr_valid", bus.valid, 1'b1);
        chk("ferr_data", 32'(bus.data), 32'h055);
        chk("ferr_width", ferr_max, 1);
        ack_pulse();

        // Back-to-back without ack: overrun on second
        q.push_back('{9'h011, 1'b0, 1'b0});
        q.push_back('{9'h022, 1'b0, 1'b1});
        send(9'h011, 8, 1, 1'b1, 1'b0);
        send(9'h022, 8, 1, 1'b1, 1'b0);
        settle(5);
        chk("b2b_valid", bus.valid, 1'b1);
        chk("b2b_data", 32'(bus.data), 32'h022);
        ack_pulse();

        // Reset mid-DATA with a word held
        q.push_back('{9'h05A, 1'b0, 1'b0});
        send(9'h05A, 8, 1, 1'b1, 1'b0);
        settle(5);
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        bit_out(1'b1);
        chk("pre_reset_busy", idle, 1'b0);
        rst_n = 1'b0;
        rx_in = 1'b1;
        settle(1);
        chk("mid_reset_idle", idle, 1'b1);
        chk("mid_reset_valid", bus.valid, 1'b0);
        chk("mid_reset_data", 32'(bus.data), 32'h0);
        rst_n = 1'b1;
        settle(400);
        q.push_back('{9'h03C, 1'b0, 1'b0});
        send(9'h03C, 8, 1, 1'b1, 1'b0);
        settle(5);
        chk("3c_valid", bus.valid, 1'b1);
        chk("3c_data", 32'(bus.data), 32'h03C);
        ack_pulse();

        settle(10);
        chk("queue_empty", q.size(), 0);
        chk("event_count", events, 7);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
